// File: rtl/vec_lsu.sv
// Vector load/store engine: moves up to LANES strided elements between a 16-bit
// memory port and a packed vector image, with back-pressure and address-wrap reporting.
module vec_lsu #(
  parameter int LANES  = 16,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 16,
  localparam int LW    = $clog2(LANES) + 1
) (
  input  logic                    Clk1,
  input  logic                    Reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [ADDR_W-1:0]       req_base,
  input  logic [ADDR_W-1:0]       req_stride,
  input  logic [LW-1:0]           req_len,
  input  logic [LANES*ELEM_W-1:0] req_wdata,
  input  logic [ELEM_W-1:0]       req_sdata,
  output logic                    done,
  output logic [LANES*ELEM_W-1:0] ld_data,
  output logic                    wrap,
  output logic [ADDR_W-1:0]       Addr,
  output logic                    RD,
  output logic                    WR,
  output logic [ELEM_W-1:0]       dataOut,
  input  logic [ELEM_W-1:0]       DataIn,
  input  logic                    mem_ready
);

  typedef enum logic [2:0] {IDLE, LD_ISSUE, LD_TAIL, ST_ISSUE, DONE} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       stride_q;
  logic [LW-1:0]           len_q;
  logic [LW-1:0]           cnt;
  logic [LANES*ELEM_W-1:0] wdata_q;
  logic                    rd_pend;

  logic [ADDR_W:0]         addr_sum;
  logic [LW-1:0]           req_len_eff;
  logic [LW-1:0]           cap_idx;
  logic [LW-1:0]           nxt_idx;
  logic                    last;

  function automatic logic [ELEM_W-1:0] lane_sel(input logic [LANES*ELEM_W-1:0] v,
                                                 input logic [LW-1:0] idx);
    logic [ELEM_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      if (idx == LW'(i)) r = v[i*ELEM_W +: ELEM_W];
    return r;
  endfunction

  // The extra top bit of the sum is the carry that marks an address wrap.
  assign addr_sum = {1'b0, Addr} + {1'b0, stride_q};
  assign cap_idx  = cnt - LW'(1);
  assign nxt_idx  = cnt + LW'(1);
  assign last     = (cnt == len_q - LW'(1));

  always_comb begin
    req_len_eff = req_len;
    if (req_len == '0 || req_len > LW'(LANES)) req_len_eff = LW'(LANES);
  end

  always_ff @(posedge Clk1 or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      done      <= 1'b0;
      RD        <= 1'b0;
      WR        <= 1'b0;
      Addr      <= '0;
      dataOut   <= '0;
      ld_data   <= '0;
      wrap      <= 1'b0;
      stride_q  <= '0;
      len_q     <= '0;
      cnt       <= '0;
      wdata_q   <= '0;
      rd_pend   <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= RD & mem_ready;
      // Read data arrives one cycle after acceptance, for the lane just counted.
      if (rd_pend)
        for (int i = 0; i < LANES; i++)
          if (cap_idx == LW'(i)) ld_data[i*ELEM_W +: ELEM_W] <= DataIn;

      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            stride_q  <= req_stride;
            len_q     <= req_len_eff;
            wdata_q   <= req_wdata;
            Addr      <= req_base;
            cnt       <= '0;
            wrap      <= 1'b0;
            case (req_op)
              2'b00: begin
                ld_data <= '0;
                RD      <= 1'b1;
                state   <= LD_ISSUE;
              end
              2'b01: begin
                WR      <= 1'b1;
                dataOut <= req_wdata[ELEM_W-1:0];
                state   <= ST_ISSUE;
              end
              2'b10: begin
                len_q   <= LW'(1);
                WR      <= 1'b1;
                dataOut <= req_sdata;
                state   <= ST_ISSUE;
              end
              default: begin
                done  <= 1'b1;
                state <= DONE;
              end
            endcase
          end
        end
        LD_ISSUE: begin
          if (mem_ready) begin
            cnt <= nxt_idx;
            // The accumulator only steps toward addresses that will be used.
            if (last) begin
              RD    <= 1'b0;
              state <= LD_TAIL;
            end else begin
              Addr <= addr_sum[ADDR_W-1:0];
              wrap <= wrap | addr_sum[ADDR_W];
            end
          end
        end
        LD_TAIL: begin
          done  <= 1'b1;
          state <= DONE;
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            if (last) begin
              WR    <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cnt     <= nxt_idx;
              Addr    <= addr_sum[ADDR_W-1:0];
              wrap    <= wrap | addr_sum[ADDR_W];
              dataOut <= lane_sel(wdata_q, nxt_idx);
            end
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_lsu.sv
// Self-checking bench for vec_lsu: table of request vectors with hand-computed
// timing, plus directed reset-abort and back-to-back request sequences.
module tb_vec_lsu;
  localparam int LANES = 16;
  localparam int EW    = 16;
  localparam int AW    = 16;
  localparam int LW    = 5;

  logic              Clk1, Reset;
  logic              req_valid, req_ready;
  logic [1:0]        req_op;
  logic [AW-1:0]     req_base, req_stride;
  logic [LW-1:0]     req_len;
  logic [LANES*EW-1:0] req_wdata;
  logic [EW-1:0]     req_sdata;
  logic              done, wrap;
  logic [LANES*EW-1:0] ld_data;
  logic [AW-1:0]     Addr;
  logic              RD, WR;
  logic [EW-1:0]     dataOut, DataIn;
  logic              mem_ready;

  vec_lsu #(.LANES(LANES), .ELEM_W(EW), .ADDR_W(AW)) dut (
    .Clk1(Clk1), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_base(req_base), .req_stride(req_stride), .req_len(req_len),
    .req_wdata(req_wdata), .req_sdata(req_sdata),
    .done(done), .ld_data(ld_data), .wrap(wrap),
    .Addr(Addr), .RD(RD), .WR(WR), .dataOut(dataOut), .DataIn(DataIn),
    .mem_ready(mem_ready)
  );

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  // Memory model: M[a] = a, read data one cycle after an accepted read.
  initial DataIn = '0;
  always @(posedge Clk1) if (RD && mem_ready) DataIn <= Addr;

  typedef struct {
    logic [1:0]          op;
    logic [15:0]         base;
    logic [15:0]         stride;
    logic [4:0]          len;
    logic [LANES*EW-1:0] wdata;
    logic [15:0]         sdata;
    logic [31:0]         stall_mask;
    int                  exp_done;
    int                  exp_strobes;
    logic                exp_wrap;
  } vec_t;

  vec_t tbl [8];
  int n_checks = 0;
  int n_fail   = 0;
  logic [LANES*EW-1:0] exp_ld = '0;

  task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    int eff, acc, strobes, done_cyc;
    logic [15:0] ea;
    logic [LANES*EW-1:0] wtmp;
    logic [15:0] ed;
    eff = (v.len == 0 || v.len > 16) ? 16 : int'(v.len);
    if (v.op == 2'b10) eff = 1;
    if (v.op == 2'b11) eff = 0;
    @(negedge Clk1);
    req_op = v.op; req_base = v.base; req_stride = v.stride; req_len = v.len;
    req_wdata = v.wdata; req_sdata = v.sdata; req_valid = 1'b1; mem_ready = 1'b1;
    @(posedge Clk1);
    #1 req_valid = 1'b0;
    acc = 0; strobes = 0; done_cyc = -1;
    wtmp = v.wdata;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      @(negedge Clk1);
      if (RD || WR) begin
        strobes++;
        ea = v.base + 16'(acc) * v.stride;
        check_output($sformatf("v%0d c%0d addr", idx, c), 256'(Addr), 256'(ea));
        check_output($sformatf("v%0d c%0d strobe", idx, c), 256'({RD, WR}),
                     256'((v.op == 2'b00) ? 2'b10 : 2'b01));
        if (WR) begin
          ed = (v.op == 2'b10) ? v.sdata : wtmp[acc*16 +: 16];
          check_output($sformatf("v%0d c%0d dataOut", idx, c), 256'(dataOut), 256'(ed));
        end
      end
      if (done) begin
        done_cyc = c;
        check_output($sformatf("v%0d req_ready at done", idx), 256'(req_ready), 256'(0));
      end
      mem_ready = (c < 32) ? !v.stall_mask[c] : 1'b1;
      if ((RD || WR) && mem_ready) acc++;
    end
    mem_ready = 1'b1;
    if (v.op == 2'b00) begin
      exp_ld = '0;
      for (int i = 0; i < eff; i++) exp_ld[i*16 +: 16] = v.base + 16'(i) * v.stride;
    end
    check_output($sformatf("v%0d done cycle", idx), 256'(done_cyc), 256'(v.exp_done));
    check_output($sformatf("v%0d strobes", idx), 256'(strobes), 256'(v.exp_strobes));
    check_output($sformatf("v%0d accepts", idx), 256'(acc), 256'(eff));
    check_output($sformatf("v%0d ld_data", idx), ld_data, exp_ld);
    check_output($sformatf("v%0d wrap", idx), 256'(wrap), 256'(v.exp_wrap));
    @(negedge Clk1);
    check_output($sformatf("v%0d idle after done", idx), 256'({req_ready, done}), 256'(2'b10));
  endtask

  initial begin
    int rd_cnt, first_done, second_done, ready_cyc, first_rd, bad;

    tbl[0] = '{op:2'd0, base:16'h0100, stride:16'd1, len:5'd16, wdata:'0, sdata:16'h0,
               stall_mask:32'h0, exp_done:18, exp_strobes:16, exp_wrap:1'b0};
    tbl[1] = '{op:2'd1, base:16'h0200, stride:16'd4, len:5'd3,
               wdata:{208'h0, 16'hCCCC, 16'hBBBB, 16'hAAAA}, sdata:16'h0,
               stall_mask:32'h0, exp_done:4, exp_strobes:3, exp_wrap:1'b0};
    tbl[2] = '{op:2'd0, base:16'hFFFE, stride:16'd1, len:5'd4, wdata:'0, sdata:16'h0,
               stall_mask:32'h0, exp_done:6, exp_strobes:4, exp_wrap:1'b1};
    tbl[3] = '{op:2'd2, base:16'h0040, stride:16'd3, len:5'd5, wdata:256'hDEAD, sdata:16'h1234,
               stall_mask:32'h6, exp_done:4, exp_strobes:3, exp_wrap:1'b0};
    tbl[4] = '{op:2'd3, base:16'h0700, stride:16'd1, len:5'd4, wdata:'0, sdata:16'h0,
               stall_mask:32'h0, exp_done:1, exp_strobes:0, exp_wrap:1'b0};
    tbl[5] = '{op:2'd0, base:16'h0010, stride:16'd0, len:5'd20, wdata:'0, sdata:16'h0,
               stall_mask:32'h88, exp_done:20, exp_strobes:18, exp_wrap:1'b0};
    tbl[6] = '{op:2'd0, base:16'h8000, stride:16'h1000, len:5'd9, wdata:'0, sdata:16'h0,
               stall_mask:32'h0, exp_done:11, exp_strobes:9, exp_wrap:1'b1};
    tbl[7] = '{op:2'd1, base:16'hFFFF, stride:16'd5, len:5'd1, wdata:256'h5A5A, sdata:16'h0,
               stall_mask:32'h0, exp_done:2, exp_strobes:1, exp_wrap:1'b0};

    req_valid = 1'b0; req_op = '0; req_base = '0; req_stride = '0; req_len = '0;
    req_wdata = '0; req_sdata = '0; mem_ready = 1'b1;
    Reset = 1'b1;
    #12;
    check_output("reset outputs", 256'({req_ready, done, RD, WR, wrap}), 256'(5'b10000));
    check_output("reset Addr/dataOut", 256'({Addr, dataOut}), 256'(0));
    check_output("reset ld_data", ld_data, 256'(0));
    @(negedge Clk1);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) apply_stimulus(i, tbl[i]);

    // Reset in the middle of a load aborts it and discards partial data.
    @(negedge Clk1);
    req_op = 2'b00; req_base = 16'h0500; req_stride = 16'd1; req_len = 5'd8; req_valid = 1'b1;
    @(posedge Clk1);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) @(negedge Clk1);
    check_output("abort RD before reset", 256'(RD), 256'(1));
    Reset = 1'b1;
    #1;
    check_output("abort RD/WR/done", 256'({RD, WR, done}), 256'(0));
    check_output("abort req_ready", 256'(req_ready), 256'(1));
    check_output("abort ld_data", ld_data, 256'(0));
    #2 Reset = 1'b0;
    exp_ld = '0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge Clk1);
      if (done || RD || WR) bad++;
    end
    check_output("abort no strobes/done", 256'(bad), 256'(0));
    apply_stimulus(8, tbl[0]);

    // req_valid held high: store then a len=0 load queued behind it.
    @(negedge Clk1);
    req_op = 2'b01; req_base = 16'h0600; req_stride = 16'd1; req_len = 5'd3;
    req_wdata = {208'h0, 16'h0003, 16'h0002, 16'h0001}; req_valid = 1'b1;
    @(posedge Clk1);
    #1;
    req_op = 2'b00; req_base = 16'h0300; req_stride = 16'd2; req_len = 5'd0;
    rd_cnt = 0; first_done = -1; second_done = -1; ready_cyc = -1; first_rd = -1; bad = 0;
    for (int c = 1; c <= 40 && second_done < 0; c++) begin
      @(negedge Clk1);
      if (c == 6) req_valid = 1'b0;
      if (c <= 4 && req_ready) bad++;
      if (req_ready && ready_cyc < 0) ready_cyc = c;
      if (RD) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = c;
      end
      if (done) begin
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
    end
    exp_ld = '0;
    for (int i = 0; i < 16; i++) exp_ld[i*16 +: 16] = 16'h0300 + 16'(2 * i);
    check_output("b2b busy ignores req_valid", 256'(bad), 256'(0));
    check_output("b2b store done cycle", 256'(first_done), 256'(4));
    check_output("b2b ready cycle", 256'(ready_cyc), 256'(5));
    check_output("b2b first RD cycle", 256'(first_rd), 256'(6));
    check_output("b2b RD count len0", 256'(rd_cnt), 256'(16));
    check_output("b2b load done cycle", 256'(second_done), 256'(23));
    check_output("b2b ld_data", ld_data, exp_ld);
    check_output("b2b wrap", 256'(wrap), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
